// File: rtl/csm_coeff_loader_pkg.sv
// Shared widths and FSM state type for the CSM coefficient loader.
`timescale 1ns/1ps
package csm_coeff_loader_pkg;

    localparam int unsigned CSM_COEFF_W = 17;
    localparam int unsigned CSM_DATA_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SWAP = 2'd2
    } csm_state_e;

    function automatic logic tap_is_nz(input logic [CSM_COEFF_W-1:0] tap);
        return |tap[CSM_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/csm_coeff_loader_sm_encode.sv
// Combinational Q15 two's-complement to {sign, magnitude} encoder (csm_sm_encode).
`timescale 1ns/1ps
module csm_sm_encode
    import csm_coeff_loader_pkg::*;
(
    input  logic [CSM_DATA_W-1:0]  coeff_i,
    output logic [CSM_COEFF_W-1:0] sm_o
);

    logic [CSM_DATA_W-1:0] mag;

    // -32768 negates to itself, which is the required 0x8000 magnitude
    always_comb begin
        mag  = coeff_i[CSM_DATA_W-1] ? (~coeff_i + 1'b1) : coeff_i;
        sm_o = {coeff_i[CSM_DATA_W-1], mag};
    end

endmodule

// File: rtl/csm_coeff_loader.sv
// Double-buffered FIR coefficient loader: fills a shadow bank, then swaps it atomically.
// Optional build macro CSM_COEFF_NZ_MASK_EN adds the registered tap_nz output.
`timescale 1ns/1ps
module csm_coeff_loader
    import csm_coeff_loader_pkg::*;
#(
    parameter int unsigned NTAPS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CSM_DATA_W-1:0]        in_coeff,
    input  logic                         in_last,
    output logic [NTAPS*CSM_COEFF_W-1:0] coeff_bus,
    output logic                         bank_update,
`ifdef CSM_COEFF_NZ_MASK_EN
    output logic [NTAPS-1:0]             tap_nz,
`endif
    output logic                         load_err
);

    localparam int unsigned    IDX_W    = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS - 1);

    csm_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CSM_COEFF_W-1:0]  shadow_q [NTAPS];
    logic [CSM_COEFF_W-1:0]  active_q [NTAPS];
    logic                    commit_q;
    logic                    bank_update_q;
    logic                    load_err_q;
    logic                    err_pend_q;

    logic [CSM_COEFF_W-1:0]  enc_beat;
    logic                    hs;
    logic                    at_end;
    logic                    load_ok;
    logic                    load_bad;
    logic                    err_any;

    csm_sm_encode u_enc (
        .coeff_i (in_coeff),
        .sm_o    (enc_beat)
    );

    always_comb begin
        in_ready = (state_q != ST_SWAP);
        hs       = in_valid & in_ready;
        at_end   = (idx_q == LAST_IDX);
        load_ok  = hs & in_last & at_end;
        load_bad = hs & (in_last ^ at_end);
        err_any  = load_bad | err_pend_q;

        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE, ST_FILL: begin
                if (hs) begin
                    if (load_ok) begin
                        state_d = ST_SWAP;
                        idx_d   = '0;
                    end else if (load_bad) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_FILL;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            ST_SWAP: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Copy happens one edge after SWAP exit so bus and pulse land together two
    // edges after the last beat; the shadow cannot change in between. An error
    // coinciding with the bank_update cycle is held back one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            commit_q      <= 1'b0;
            bank_update_q <= 1'b0;
            load_err_q    <= 1'b0;
            err_pend_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            commit_q      <= (state_q == ST_SWAP);
            bank_update_q <= commit_q;
            load_err_q    <= err_any & ~commit_q;
            err_pend_q    <= err_any & commit_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                if (hs && (idx_q == IDX_W'(i))) begin
                    shadow_q[i] <= enc_beat;
                end
                if (commit_q) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    always_comb begin
        coeff_bus = '0;
        for (int unsigned i = 0; i < NTAPS; i++) begin
            coeff_bus[i*CSM_COEFF_W +: CSM_COEFF_W] = active_q[i];
        end
    end

    assign bank_update = bank_update_q;
    assign load_err    = load_err_q;

`ifdef CSM_COEFF_NZ_MASK_EN
    logic [NTAPS-1:0] tap_nz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_nz_q <= '0;
        end else if (commit_q) begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                tap_nz_q[i] <= tap_is_nz(shadow_q[i]);
            end
        end
    end

    assign tap_nz = tap_nz_q;
`endif

endmodule

// File: tb/tb_csm_coeff_loader.sv
// Randomized self-checking bench for csm_coeff_loader against a transaction-level model.
`timescale 1ns/1ps
module tb_csm_coeff_loader;

    localparam int N  = 8;
    localparam int BW = N * 17;
    typedef logic [BW-1:0] vec_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_coeff;
    logic          in_last;
    logic [BW-1:0] coeff_bus;
    logic          bank_update;
    logic          load_err;
`ifdef CSM_COEFF_NZ_MASK_EN
    logic [N-1:0]  tap_nz;
`endif

    csm_coeff_loader #(.NTAPS(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_coeff    (in_coeff),
        .in_last     (in_last),
        .coeff_bus   (coeff_bus),
        .bank_update (bank_update),
`ifdef CSM_COEFF_NZ_MASK_EN
        .tap_nz      (tap_nz),
`endif
        .load_err    (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input vec_t obs, input vec_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: a load is a list of accepted beats; a correct load becomes
    // visible two edges after its last beat, and in_ready drops on the edge between.
    logic [16:0] m_active  [N];
    logic [16:0] m_pending [N];
    int          m_beats   [$];
    int          m_swap_cnt;
    bit          m_err_pend;
    bit          exp_bu;
    bit          exp_err;

    function automatic logic [16:0] enc(input int v);
        if (v < 0) return {1'b1, 16'(-v)};
        return {1'b0, 16'(v)};
    endfunction

    function automatic vec_t pack_active();
        vec_t r = '0;
        for (int i = 0; i < N; i++) r[i*17 +: 17] = m_active[i];
        return r;
    endfunction

    function automatic bit m_ready();
        return m_swap_cnt != 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_active[i]  = '0;
            m_pending[i] = '0;
        end
        m_beats.delete();
        m_swap_cnt = 0;
        m_err_pend = 0;
        exp_bu     = 0;
        exp_err    = 0;
    endtask

    task automatic model_step(output bit hs);
        bit committed = 0;
        bit err_now   = 0;
        hs = in_valid && m_ready();
        if (m_swap_cnt > 0) begin
            m_swap_cnt--;
            if (m_swap_cnt == 0) begin
                m_active  = m_pending;
                committed = 1;
            end
        end
        if (hs) begin
            m_beats.push_back(int'($signed(in_coeff)));
            if (in_last && m_beats.size() == N) begin
                for (int i = 0; i < N; i++) m_pending[i] = enc(m_beats[i]);
                m_swap_cnt = 2;
                m_beats.delete();
            end else if (in_last || m_beats.size() == N) begin
                err_now = 1;
                m_beats.delete();
            end
        end
        exp_bu     = committed;
        exp_err    = (err_now || m_err_pend) && !committed;
        m_err_pend = (err_now || m_err_pend) && committed;
    endtask

    task automatic compare_all();
        check_eq("in_ready", vec_t'(in_ready), vec_t'(m_ready()));
        check_eq("bank_update", vec_t'(bank_update), vec_t'(exp_bu));
        check_eq("load_err", vec_t'(load_err), vec_t'(exp_err));
        check_eq("coeff_bus", coeff_bus, pack_active());
`ifdef CSM_COEFF_NZ_MASK_EN
        begin
            logic [N-1:0] nz;
            for (int i = 0; i < N; i++) nz[i] = (m_active[i][15:0] != 16'h0);
            check_eq("tap_nz", vec_t'(tap_nz), vec_t'(nz));
        end
`endif
    endtask

    task automatic tick(output bit hs);
        @(posedge clk);
        model_step(hs);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        bit hs;
        in_valid = 0;
        in_last  = 0;
        repeat (n) tick(hs);
    endtask

    function automatic logic [15:0] rand_coeff();
        case ($urandom_range(7))
            0:       return 16'h8000;
            1:       return 16'h0000;
            2:       return 16'hFFFF;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic send_beat(input logic [15:0] c, input logic l, input int pvalid);
        bit hs   = 0;
        int tries = 0;
        while (!hs && tries < 64) begin
            in_valid = (int'($urandom_range(99)) < pvalid);
            if (in_valid) begin
                in_coeff = c;
                in_last  = l;
            end else begin
                in_coeff = 16'($urandom);
                in_last  = 1'($urandom);
            end
            tick(hs);
            tries++;
        end
        if (!hs) check_eq("handshake_timeout", vec_t'(0), vec_t'(1));
        in_valid = 0;
        in_last  = 0;
    endtask

    logic [15:0] tx_q [$];

    task automatic send_q(input bit last_on_final, input int pvalid);
        for (int b = 0; b < tx_q.size(); b++)
            send_beat(tx_q[b], last_on_final && (b == tx_q.size() - 1), pvalid);
        tx_q.delete();
    endtask

    task automatic queue_d30();
        tx_q = '{16'h4000, 16'hC000, 16'h8000, 16'h0000,
                 16'h7FFF, 16'hFFFF, 16'h0001, 16'h1234};
    endtask

    task automatic queue_random(input int len);
        for (int b = 0; b < len; b++) tx_q.push_back(rand_coeff());
    endtask

    vec_t exp30;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [16:0] taps30 [N];
        taps30 = '{17'h04000, 17'h14000, 17'h18000, 17'h00000,
                   17'h07FFF, 17'h10001, 17'h00001, 17'h01234};
        exp30 = '0;
        for (int i = 0; i < N; i++) exp30[i*17 +: 17] = taps30[i];

        rst_n    = 0;
        in_valid = 0;
        in_coeff = '0;
        in_last  = 0;
        model_reset();
        #13;
        check_eq("reset_bus", coeff_bus, '0);
        check_eq("reset_bu", vec_t'(bank_update), '0);
        check_eq("reset_err", vec_t'(load_err), '0);
        @(negedge clk);
        rst_n = 1;
        idle(4);

        queue_d30();
        send_q(1, 100);
        idle(3);
        check_eq("d30_bank", coeff_bus, exp30);

        queue_random(5);
        send_q(1, 100);
        idle(3);
        check_eq("early_last_keeps_bank", coeff_bus, exp30);
        queue_random(N);
        send_q(1, 100);
        idle(3);

        queue_random(N);
        send_q(0, 100);
        idle(3);

        queue_d30();
        send_q(1, 50);
        idle(3);
        check_eq("d30_gappy_bank", coeff_bus, exp30);

        for (int t = 0; t < 40; t++) begin
            int kind   = int'($urandom_range(3));
            int pvalid = int'($urandom_range(30, 100));
            if (kind <= 1) begin
                queue_random(N);
                send_q(1, pvalid);
            end else if (kind == 2) begin
                queue_random(int'($urandom_range(1, N - 1)));
                send_q(1, pvalid);
            end else begin
                queue_random(N);
                send_q(0, pvalid);
            end
            idle(int'($urandom_range(2, 4)));
        end

        queue_random(N);
        send_q(1, 100);
        idle(3);
        queue_random(3);
        send_q(0, 100);
        #2;
        rst_n = 0;
        #1;
        check_eq("midload_rst_bus", coeff_bus, '0);
        check_eq("midload_rst_bu", vec_t'(bank_update), '0);
        check_eq("midload_rst_err", vec_t'(load_err), '0);
`ifdef CSM_COEFF_NZ_MASK_EN
        check_eq("midload_rst_nz", vec_t'(tap_nz), '0);
`endif
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        idle(5);

        queue_d30();
        send_q(1, 100);
        idle(3);
        check_eq("d30_after_reset", coeff_bus, exp30);
`ifdef CSM_COEFF_NZ_MASK_EN
        check_eq("d30_tap_nz", vec_t'(tap_nz), vec_t'(8'b1111_0111));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csm_coeff_loader.md
CSM_COEFF_LOADER -- requirements
Module: csm_coeff_loader

Interface
REQ-001 SHALL have parameter NTAPS, default 8, giving the number of FIR taps held (legal range 2..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the host offers a coefficient beat.
REQ-005 SHALL have port in_ready, output, 1 bit: the loader accepts a beat.
REQ-006 SHALL have port in_coeff, input, 16 bits: signed two's-complement Q15 coefficient.
REQ-007 SHALL have port in_last, input, 1 bit: marks the final beat of a load.
REQ-008 SHALL have port coeff_bus, output, NTAPS*17 bits: active bank; tap i is at [17*i+16:17*i] as {sign, magnitude[15:0]}, matching the CSM coeff input format.
REQ-009 SHALL have port bank_update, output, 1 bit: one-cycle pulse when coeff_bus changes.
REQ-010 SHALL have port load_err, output, 1 bit: one-cycle pulse when a load is discarded.

Function
REQ-011 SHALL complete a handshake on any rising edge where in_valid=1 and in_ready=1.
REQ-012 SHALL encode each accepted beat as sign=in_coeff[15], magnitude=|in_coeff| as unsigned 16 bits; -32768 -> {1, 0x8000}; 0 -> {0, 0x0000} (never negative zero).
REQ-013 SHALL write the encoded beat into a shadow bank at index idx, where idx starts at 0 on each load and increments per handshake.
REQ-014 SHALL implement FSM states IDLE, FILL and SWAP.
REQ-015 IDLE: in_ready=1; a handshake writes idx 0, then goes to FILL, or goes straight to SWAP if in_last=1 and NTAPS==1 is excluded (so in_last=1 here -> error, REQ-018).
REQ-016 FILL: in_ready=1; a handshake with idx==NTAPS-1 and in_last=1 goes to SWAP.
REQ-017 SWAP: in_ready=0 for exactly one cycle; on the exit edge the shadow bank is copied to the active bank, bank_update=1 for the following cycle, and the FSM returns to IDLE.
REQ-018 SHALL, on a handshake with in_last=1 and idx<NTAPS-1, or in_last=0 and idx==NTAPS-1, discard the shadow bank, leave the active bank unchanged, pulse load_err for the next cycle, and go to IDLE.
REQ-019 Latency: last beat accepted at edge k; new coeff_bus and bank_update=1 visible from edge k+1 plus one (edge k+2), with zero glitches between.
REQ-020 SHALL never expose a partially written bank on coeff_bus.
REQ-021 SHALL leave coeff_bus stable between bank_update pulses.
REQ-022 SHALL never assert bank_update and load_err in the same cycle.

Reset
REQ-023 rst_n=0 SHALL asynchronously force: FSM=IDLE, idx=0, all shadow and active taps=0, bank_update=0, load_err=0; in_ready=1 after release.
REQ-024 Reset mid-load SHALL abandon the load with no bank_update and no load_err pulse.

Configuration
REQ-025 Macro CSM_COEFF_NZ_MASK_EN defined: SHALL add output tap_nz[NTAPS-1:0], registered; bit i=1 iff active tap i magnitude!=0; updates on the same edge as coeff_bus; resets to 0.
REQ-026 Without CSM_COEFF_NZ_MASK_EN: no tap_nz port, no related logic.

Structure
REQ-027 The shared package SHALL hold the CSM_COEFF_W=17 and CSM_DATA_W=16 constants and the FSM state enumeration.
REQ-028 The two's-complement to sign-magnitude encoder SHALL be one combinational sub-module, csm_sm_encode.

Verification
REQ-029 Reset then idle: coeff_bus=0, in_ready=1, no pulses.
REQ-030 NTAPS=8, load 0x4000,0xC000,0x8000,0x0000,0x7FFF,0xFFFF,0x0001,0x1234 with in_last on beat 8: taps = {0,4000},{1,4000},{1,8000},{0,0000},{0,7FFF},{1,0001},{0,0001},{0,1234}; single bank_update two edges after last beat; in_ready=0 during SWAP.
REQ-031 in_last on beat 5 of 8: load_err pulses once; coeff_bus keeps prior bank; next full load succeeds.
REQ-032 8 beats without in_last: load_err pulses once on beat 8; no bank_update.
REQ-033 in_valid toggled randomly during a valid load: same final bank as REQ-030; coeff_bus unchanged until bank_update.
REQ-034 rst_n low after beat 3: all outputs 0 asynchronously; no pulses after release; CSM_COEFF_NZ_MASK_EN build shows tap_nz=8'b1111_0111 after REQ-030 load.
